// File: rtl/switch_debouncer.sv
// Per-bit synchroniser and debounce filter for raw switch/button pins feeding the PIO input port.
// A level is accepted only after DEBOUNCE_CYCLES stable cycles; each acceptance emits a one-cycle change pulse.
module switch_debouncer #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit PARAM_OK = (DEBOUNCE_CYCLES >= 1) &&
                            (longint'(DEBOUNCE_CYCLES) < (longint'(1) << CNT_W));

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] update;
  logic [CNT_W-1:0] cnt [WIDTH];

  // sync1 is the only flop exposed to metastability; it is a false path from the pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (sync2[i] != sw_stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Any return to the accepted level restarts timing, so the counter never exceeds CNT_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == sw_stable[i]) || update[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable  <= RESET_VALUE;
      sw_changed <= '0;
      any_change <= 1'b0;
    end else begin
      sw_stable  <= sw_stable ^ update;
      sw_changed <= update;
      any_change <= |update;
    end
  end

  param_check: assert property (@(posedge clk) PARAM_OK)
    else $error("switch_debouncer: DEBOUNCE_CYCLES must lie in 1 .. 2**CNT_W-1");

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4: reset, clean change, glitch, bounce,
// simultaneous change and reset mid-count, each checked against hand-computed edge numbers.
module tb_switch_debouncer;

  logic       clk;
  logic       reset_n;
  logic [7:0] sw_raw;
  logic [7:0] sw_stable;
  logic [7:0] sw_changed;
  logic       any_change;

  int assertCount;
  int failCount;

  switch_debouncer #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .sw_changed(sw_changed),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] raw);
    sw_raw = raw;
  endtask

  initial begin
    int pulses;
    int firstEdge;
    int secondEdge;
    int anyCount;
    logic [7:0] seen;

    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b0;
    applyStimulus(8'hFF);

    // Test 1: reset state, then full latency after release
    tick();
    tick();
    checkOutput("reset_stable", sw_stable, 8'h00);
    checkOutput("reset_changed", sw_changed, 8'h00);
    checkOutput("reset_any", {7'b0, any_change}, 8'h00);
    reset_n = 1'b1;
    seen = 8'h00;
    for (int e = 0; e < 5; e++) begin
      tick();
      seen = seen | sw_stable | sw_changed;
    end
    checkOutput("rel_no_early", seen, 8'h00);
    tick();
    checkOutput("rel_stable", sw_stable, 8'hFF);
    checkOutput("rel_changed", sw_changed, 8'hFF);
    checkOutput("rel_any", {7'b0, any_change}, 8'h01);
    tick();
    checkOutput("rel_changed_off", sw_changed, 8'h00);
    checkOutput("rel_any_off", {7'b0, any_change}, 8'h00);

    applyStimulus(8'h00);
    for (int e = 0; e < 8; e++) tick();
    checkOutput("settle_zero", sw_stable, 8'h00);

    // Test 2: clean change on bit 3
    applyStimulus(8'h08);
    for (int e = 0; e < 5; e++) tick();
    checkOutput("clean_before", sw_stable, 8'h00);
    checkOutput("clean_before_pulse", sw_changed, 8'h00);
    tick();
    checkOutput("clean_stable", sw_stable, 8'h08);
    checkOutput("clean_changed", sw_changed, 8'h08);
    checkOutput("clean_any", {7'b0, any_change}, 8'h01);
    tick();
    checkOutput("clean_changed_off", sw_changed, 8'h00);

    // Test 3a: 3-cycle glitch on bit 0 is rejected
    applyStimulus(8'h09);
    seen = 8'h00;
    for (int e = 0; e < 12; e++) begin
      if (e == 3) applyStimulus(8'h08);
      tick();
      seen = seen | sw_changed | {7'b0, any_change};
    end
    checkOutput("glitch_pulses", seen, 8'h00);
    checkOutput("glitch_stable", sw_stable, 8'h08);

    // Test 3b: 4-cycle pulse is accepted, and its release also propagates
    applyStimulus(8'h09);
    pulses = 0;
    firstEdge = -1;
    secondEdge = -1;
    for (int e = 0; e < 15; e++) begin
      if (e == 4) applyStimulus(8'h08);
      tick();
      if (sw_changed[0]) begin
        pulses++;
        if (firstEdge < 0) firstEdge = e;
        else secondEdge = e;
      end
      if (e == 5) checkOutput("minpulse_high", sw_stable, 8'h09);
    end
    checkOutput("minpulse_count", 8'(pulses), 8'd2);
    checkOutput("minpulse_rise_edge", 8'(firstEdge), 8'd5);
    checkOutput("minpulse_fall_edge", 8'(secondEdge), 8'd9);
    checkOutput("minpulse_final", sw_stable, 8'h08);

    // Test 4: bounce on bit 5, final transition before edge 4
    pulses = 0;
    firstEdge = -1;
    for (int e = 0; e < 16; e++) begin
      if (e < 4) applyStimulus((e % 2 == 0) ? 8'h28 : 8'h08);
      else applyStimulus(8'h28);
      tick();
      if (sw_changed[5]) begin
        pulses++;
        if (firstEdge < 0) firstEdge = e;
      end
    end
    checkOutput("bounce_count", 8'(pulses), 8'd1);
    checkOutput("bounce_edge", 8'(firstEdge), 8'd9);
    checkOutput("bounce_stable", sw_stable, 8'h28);

    // Test 5: bits 1 and 6 together while bit 2 bounces
    seen = 8'h00;
    anyCount = 0;
    for (int e = 0; e < 12; e++) begin
      applyStimulus((e < 6 && e % 2 == 0) ? 8'h6E : 8'h6A);
      tick();
      seen = seen | sw_changed;
      if (any_change) anyCount++;
      if (e == 5) begin
        checkOutput("simul_changed", sw_changed, 8'h42);
        checkOutput("simul_any", {7'b0, any_change}, 8'h01);
        checkOutput("simul_stable", sw_stable, 8'h6A);
      end
      if (e == 6) checkOutput("simul_any_off", {7'b0, any_change}, 8'h00);
    end
    checkOutput("simul_all_pulses", seen, 8'h42);
    checkOutput("simul_any_count", 8'(anyCount), 8'd1);

    // Test 6: reset two cycles into a bit-4 count
    applyStimulus(8'h7A);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_stable", sw_stable, 8'h00);
    checkOutput("midreset_changed", sw_changed, 8'h00);
    tick();
    reset_n = 1'b1;
    seen = 8'h00;
    for (int e = 0; e < 5; e++) begin
      tick();
      seen = seen | sw_stable | sw_changed;
    end
    checkOutput("midreset_no_early", seen, 8'h00);
    tick();
    checkOutput("midreset_stable_after", sw_stable, 8'h7A);
    checkOutput("midreset_changed_after", sw_changed, 8'h7A);
    checkOutput("midreset_any_after", {7'b0, any_change}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the raw slide-switch/push-button inputs before they reach the PIO input port that the Nios II reads over Avalon. Each bit is synchronised to `clk` with two flops. Each bit also gets its own debounce counter, so a level change propagates only after it has been stable for a programmable number of cycles. Alongside the clean levels, the block emits per-bit and aggregate one-cycle change pulses for use as future interrupt/edge-capture sources.

## Interface
- `WIDTH`, 8, number of switch bits.
- `DEBOUNCE_CYCLES`, 50000, cycles a synchronised level must hold before acceptance (1 ms at 50 MHz); legal range 1 to 2^CNT_W−1.
- `CNT_W`, 16, width of each per-bit counter.
- `RESET_VALUE`, 0, value of `sw_stable` and of the synchroniser flops during reset (WIDTH bits).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `sw_raw`  in  WIDTH  asynchronous switch pins, unsynchronised, may bounce.
- `sw_stable`  out  WIDTH  debounced level, registered; drives PIO `in_port`.
- `sw_changed`  out  WIDTH  per-bit one-cycle pulse when the corresponding `sw_stable` bit updates.
- `any_change`  out  1  registered OR of the update conditions; high in the same cycle as any `sw_changed` bit.

## Operation
- **Synchroniser:** `sync1 <= sw_raw`, `sync2 <= sync1`, per bit.
- **Per-bit debounce, evaluated every edge:**
  - `sync2[i] == sw_stable[i]`: `cnt[i] <= 0`, no pulse.
  - `sync2[i] != sw_stable[i]` and `cnt[i] != DEBOUNCE_CYCLES−1`: `cnt[i] <= cnt[i]+1`.
  - `sync2[i] != sw_stable[i]` and `cnt[i] == DEBOUNCE_CYCLES−1`: `sw_stable[i] <= sync2[i]`, `cnt[i] <= 0`, `sw_changed[i] <= 1`.
- **Pulse behaviour:**
  - `sw_changed[i]` is 0 on every edge where no update occurs, so pulses are exactly one cycle wide.
  - `any_change` is registered as the OR of the per-bit update conditions.
- **Glitch rejection:** any return of `sync2[i]` to `sw_stable[i]` before the count completes clears `cnt[i]`, and timing restarts from zero on the next mismatch.
- **Independence:** bits are fully independent; simultaneous updates on several bits produce simultaneous `sw_changed` bits and a single `any_change` cycle.
- **Counter range:** the counter never exceeds DEBOUNCE_CYCLES−1, so there is no wrap-around. CNT_W must satisfy DEBOUNCE_CYCLES ≤ 2^CNT_W − 1, checked by a simulation-time assertion.
- **Reset:** asynchronous.
  - `sync1`, `sync2`, `sw_stable` are set to RESET_VALUE.
  - `cnt` is set to 0.
  - `sw_changed` and `any_change` are set to 0.
  - Reset mid-count discards partial counts. After release, a bit whose `sw_raw` differs from RESET_VALUE is accepted after the full latency below, with a `sw_changed` pulse.

## Timing
- **Change latency:** `sw_raw[i]` changes before edge 0 and holds.
  - `sync2` differs from edge 1.
  - The counter runs on edges 2 … DEBOUNCE_CYCLES+1.
  - `sw_stable[i]` and `sw_changed[i]` update on edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles of latency.
  - With DEBOUNCE_CYCLES=1, latency is 3 cycles.
- **Minimum accepted pulse:** a raw pulse shorter than DEBOUNCE_CYCLES cycles is never propagated. One of exactly DEBOUNCE_CYCLES cycles is propagated, and its release also takes DEBOUNCE_CYCLES cycles to propagate.
- **Downstream hand-off:** `sw_stable` changes only at `clk` edges and is glitch-free, so the downstream PIO's readdata register samples it directly. Avalon read data therefore lags `sw_stable` by one cycle.
- **Timing exceptions:** there are no combinational paths from `sw_raw` to any output. `sync1` is the only metastability-exposed flop and is constrained as a false path from the pins.

## Test plan
1. **Reset state:** WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VALUE=0, `sw_raw`=0xFF held through reset → `sw_stable`=0x00 and pulses 0 during reset. After release, `sw_stable`=0xFF exactly 6 edges later, with `sw_changed`=0xFF and `any_change`=1 for one cycle.
2. **Clean change:** `sw_raw[3]` 0→1 held → `sw_stable[3]`=1 on edge 5 after the change, `sw_changed`=0x08 for one cycle, other bits unaffected.
3. **Glitch rejection:** `sw_raw[0]` high for 3 cycles then low → `sw_stable[0]` stays 0, no pulse. A repeat with a 4-cycle pulse → `sw_stable[0]` rises then falls, two single-cycle pulses.
4. **Bounce:** `sw_raw[5]` toggles 1,0,1,0,1 (one cycle each) then holds 1 → `sw_stable[5]` rises 6 cycles after the final transition, exactly one pulse.
5. **Simultaneous changes:** bits 1 and 6 change in the same cycle while bit 2 bounces → bits 1 and 6 update together, `sw_changed`=0x42, `any_change` high for one cycle.
6. **Reset mid-count:** `sw_raw[4]` rises, `reset_n` asserted 2 cycles later for 1 cycle → `sw_stable[4]`=0 during reset. Full 6-cycle latency is counted from release, and there is no early update.
